// File: rtl/org_lcu_loader_pkg.sv
// rtl/org_lcu_loader_pkg.sv - shared types, constants and address helper for the LCU loader
// Contents:
//   PIXEL_WIDTH, BEAT_PIX, LINE_PIX, BEAT_W, LINE_W  pixel and bus geometry
//   LUMA_BASE, CB_BASE, CR_BASE, LCU_LINES           line-buffer address map
//   state_t                                          loader FSM states
//   line_addr()                                      line address for a plane/row/half
package org_lcu_loader_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int BEAT_PIX    = 16;
  localparam int LINE_PIX    = 32;
  localparam int BEAT_W      = PIXEL_WIDTH * BEAT_PIX;
  localparam int LINE_W      = PIXEL_WIDTH * LINE_PIX;

  localparam logic [7:0] LUMA_BASE = 8'd0;
  localparam logic [7:0] CB_BASE   = 8'd128;
  localparam logic [7:0] CR_BASE   = 8'd160;
  localparam int         LCU_LINES = 192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUMA,
    ST_CB,
    ST_CR,
    ST_DONE
  } state_t;

  // Luma interleaves the two 32-pixel halves of a 64-pixel row 32 lines
  // apart, with rows 32..63 in the upper 64-line block.
  function automatic logic [7:0] line_addr(input state_t st, input logic [5:0] row,
                                           input logic half);
    logic [7:0] a;
    case (st)
      ST_LUMA: a = LUMA_BASE | {1'b0, row[5], half, row[4:0]};
      ST_CB:   a = CB_BASE + {3'b000, row[4:0]};
      default: a = CR_BASE + {3'b000, row[4:0]};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/org_line_pack.sv
// rtl/org_line_pack.sv - packs pairs of 16-pixel beats into registered 32-pixel lines
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   beat_valid_i    a beat is accepted this cycle
//   beat_data_i     accepted beat, leftmost pixel in MSBs
//   line_valid_o    one-cycle strobe, cycle after the odd beat of a line
//   line_data_o     {even beat, odd beat}; holds its value between strobes
module org_line_pack
  import org_lcu_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  output logic              line_valid_o,
  output logic [LINE_W-1:0] line_data_o
);

  logic              odd_q,  odd_d;
  logic [BEAT_W-1:0] hold_q, hold_d;
  logic              wen_q,  wen_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    odd_d  = odd_q;
    hold_d = hold_q;
    wen_d  = 1'b0;
    line_d = line_q;
    if (beat_valid_i) begin
      odd_d = ~odd_q;
      if (!odd_q) begin
        hold_d = beat_data_i;
      end else begin
        wen_d  = 1'b1;
        line_d = {hold_q, beat_data_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odd_q  <= 1'b0;
      hold_q <= '0;
      wen_q  <= 1'b0;
      line_q <= '0;
    end else begin
      odd_q  <= odd_d;
      hold_q <= hold_d;
      wen_q  <= wen_d;
      line_q <= line_d;
    end
  end

  assign line_valid_o = wen_q;
  assign line_data_o  = line_q;

endmodule

// File: rtl/org_lcu_loader.sv
// rtl/org_lcu_loader.sv - loads one LCU of raw pixels into the original-pixel line buffer
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       begin one LCU load (IDLE only)
//   in_valid_i    input beat valid
//   in_ready_o    input beat accepted when valid & ready
//   in_data_i     16-pixel beat, leftmost pixel in MSBs
//   rd_req_i      buffer reader claims the port next cycle; stalls input
//   a_wen_o       line-buffer write enable, one cycle per line
//   a_addr_o      line-buffer line address
//   a_wdata_o     32-pixel line, leftmost pixel in MSBs
//   busy_o        load in progress (LUMA/CB/CR)
//   done_o        one-cycle pulse the cycle after the final write
module org_lcu_loader
  import org_lcu_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BEAT_W-1:0] in_data_i,
  input  logic              rd_req_i,
  output logic              a_wen_o,
  output logic [7:0]        a_addr_o,
  output logic [LINE_W-1:0] a_wdata_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t     state_q, state_d;
  logic [1:0] beat_q,  beat_d;
  logic [5:0] row_q,   row_d;
  logic [7:0] addr_q,  addr_d;
  // Final beat taken; holds the input closed while the last write drains.
  logic       fin_q,   fin_d;

  logic       active;
  logic       accept;
  logic       beat_last;
  logic       row_last;
  logic [7:0] cur_addr;

  assign active     = (state_q == ST_LUMA) || (state_q == ST_CB) || (state_q == ST_CR);
  assign in_ready_o = active & ~fin_q & ~rd_req_i;
  assign accept     = in_valid_i & in_ready_o;
  assign busy_o     = active;
  assign done_o     = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    row_d     = row_q;
    addr_d    = addr_q;
    fin_d     = fin_q;
    beat_last = (state_q == ST_LUMA) ? (beat_q == 2'd3) : (beat_q == 2'd1);
    // Chroma rows wrap at 32 by looking only at the low five bits.
    row_last  = (state_q == ST_LUMA) ? (row_q == 6'd63) : (row_q[4:0] == 5'd31);
    cur_addr  = line_addr(state_q, row_q, beat_q[1]);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LUMA;
          beat_d  = 2'd0;
          row_d   = 6'd0;
        end
      end
      ST_LUMA, ST_CB, ST_CR: begin
        if (accept) begin
          // The address is latched with the odd beat so it lines up with
          // the packer's registered write strobe.
          if (beat_q[0]) begin
            addr_d = cur_addr;
            if (cur_addr == 8'(LCU_LINES - 1)) begin
              fin_d = 1'b1;
            end
          end
          if (beat_last) begin
            beat_d = 2'd0;
            row_d  = row_last ? 6'd0 : row_q + 6'd1;
            if (row_last && state_q == ST_LUMA) begin
              state_d = ST_CB;
            end else if (row_last && state_q == ST_CB) begin
              state_d = ST_CR;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
        if (fin_q) begin
          state_d = ST_DONE;
          fin_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      row_q   <= 6'd0;
      addr_q  <= 8'd0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      fin_q   <= fin_d;
    end
  end

  org_line_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .beat_valid_i (accept),
    .beat_data_i  (in_data_i),
    .line_valid_o (a_wen_o),
    .line_data_o  (a_wdata_o)
  );

  assign a_addr_o = addr_q;

endmodule
